// File: rtl/ro_meas_ctrl_if.sv
// rtl/ro_meas_ctrl_if.sv - control/result bundle for the ring-oscillator measurement controller
interface ro_meas_ctrl_if #(
  parameter int NSEL   = 4,
  parameter int CNT_W  = 16,
  parameter int GATE_W = 16,
  parameter int SEL_W  = (NSEL > 1) ? $clog2(NSEL) : 1
);
  logic              START;
  logic [SEL_W-1:0]  SEL;
  logic [GATE_W-1:0] GATE;
  logic [NSEL-1:0]   RO_IN;
  logic [NSEL-1:0]   RO_EN;
  logic              BUSY;
  logic              DONE;
  logic [CNT_W-1:0]  COUNT;
  logic              OVF;

  modport master (
    output START, SEL, GATE, RO_IN,
    input  RO_EN, BUSY, DONE, COUNT, OVF
  );

  modport slave (
    input  START, SEL, GATE, RO_IN,
    output RO_EN, BUSY, DONE, COUNT, OVF
  );
endinterface

// File: rtl/ro_meas_ctrl.sv
// rtl/ro_meas_ctrl.sv - gated edge counter for a selectable ring oscillator
module ro_meas_ctrl #(
  parameter int NSEL       = 4,
  parameter int CNT_W      = 16,
  parameter int GATE_W     = 16,
  parameter int SETTLE_CYC = 8
) (
  input logic            CLK,
  input logic            RST,
  ro_meas_ctrl_if.slave  bus
);
  localparam int SEL_W  = (NSEL > 1) ? $clog2(NSEL) : 1;
  localparam int SET_W  = $clog2(SETTLE_CYC + 1);
  localparam int TMR_W  = (GATE_W > SET_W) ? GATE_W : SET_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              prev_q, prev_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [NSEL-1:0]   ro_en_q, ro_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rise;

  localparam logic [NSEL-1:0] ONE_HOT_LSB = {{(NSEL-1){1'b0}}, 1'b1};

  // Next-state, edge detection and registered-output computation. The
  // synchronizer follows the latched index, so switching oscillators leaves
  // stale samples in the chain; SETTLE flushes them before MEASURE counts.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    sel_d   = sel_q;
    gate_d  = gate_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    sync1_d = bus.RO_IN[sel_q];
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    rise    = sync2_q & ~prev_q;

    case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          state_d = S_SETTLE;
          sel_d   = bus.SEL;
          gate_d  = bus.GATE;
          timer_d = TMR_W'(SETTLE_CYC - 1);
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      S_SETTLE: begin
        if (timer_q == '0) begin
          if (gate_q == '0) begin
            state_d = S_DRAIN;
            timer_d = TMR_W'(1);
          end else begin
            state_d = S_MEASURE;
            timer_d = TMR_W'(gate_q) - TMR_W'(1);
          end
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      S_MEASURE: begin
        if (rise) begin
          if (count_q == '1) begin
            ovf_d = 1'b1;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
        if (timer_q == '0) begin
          state_d = S_DRAIN;
          timer_d = TMR_W'(1);
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      S_DRAIN: begin
        if (timer_q == '0) begin
          state_d = S_DONE;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they line up with it once registered.
    ro_en_d = ((state_d == S_SETTLE) || (state_d == S_MEASURE)) ? (ONE_HOT_LSB << sel_d) : '0;
    busy_d  = (state_d == S_SETTLE) || (state_d == S_MEASURE) || (state_d == S_DRAIN);
    done_d  = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset taking priority over everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      sel_q   <= '0;
      gate_q  <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      ro_en_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      sel_q   <= sel_d;
      gate_q  <= gate_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      ro_en_q <= ro_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.RO_EN = ro_en_q;
  assign bus.BUSY  = busy_q;
  assign bus.DONE  = done_q;
  assign bus.COUNT = count_q;
  assign bus.OVF   = ovf_q;
endmodule
